// File: rtl/bpc_pkg.sv
// ============================================================================
// Package  : bpc_pkg
// Brief    : Shared prefix codes, encoder state type and size-width helper
//            for the BPC DBX-plane stream encoder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package bpc_pkg;

    localparam int         BPC_PFX_W      = 5;
    localparam logic [4:0] BPC_PFX_ONES   = 5'b00000;
    localparam logic [4:0] BPC_PFX_DBP    = 5'b00001;
    localparam logic [4:0] BPC_PFX_CONS   = 5'b00010;
    localparam logic [4:0] BPC_PFX_SINGLE = 5'b00011;
    localparam logic [2:0] BPC_PFX_RUN1   = 3'b001;
    localparam logic [1:0] BPC_PFX_RUNN   = 2'b01;

    typedef enum logic [1:0] {
        PASS = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } bpc_state_e;

    // Width able to hold any codeword length 0..PLANE_W+1
    function automatic int bpc_sz_w(input int plane_w);
        return $clog2(plane_w + 2);
    endfunction

endpackage

`default_nettype wire

// File: rtl/bpc_dbx_classify.sv
// ============================================================================
// Module   : bpc_dbx_classify
// Brief    : Combinational DBX-plane classifier producing a left-aligned
//            codeword and its length for one non-zero plane.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpc_dbx_classify
    import bpc_pkg::*;
#(
    parameter int  PLANE_W = 63,
    parameter int  IDX_W   = $clog2(PLANE_W),
    localparam int SZ_W    = bpc_sz_w(PLANE_W)
) (
    input  logic [PLANE_W-1:0] plane_i,
    input  logic               dbp_flag_i,
    output logic               is_zero_o,
    output logic [PLANE_W:0]   code_o,
    output logic [SZ_W-1:0]    size_o
);

    localparam int                 CW      = PLANE_W + 1;
    localparam int                 POS_W   = BPC_PFX_W + IDX_W;
    localparam logic [PLANE_W-1:0] LSB_ONE = {{(PLANE_W-1){1'b0}}, 1'b1};

    logic               w_all_ones;
    logic               w_single;
    logic               w_cons;
    logic [PLANE_W-1:0] w_pair;
    logic [IDX_W-1:0]   w_idx_single;
    logic [IDX_W-1:0]   w_idx_pair;

    assign is_zero_o  = ~|plane_i;
    assign w_all_ones = &plane_i;
    // w_pair marks bit i wherever bits i and i+1 are both set
    assign w_pair     = plane_i & (plane_i >> 1);
    assign w_single   = !is_zero_o && ((plane_i & (plane_i - LSB_ONE)) == '0);
    assign w_cons     = (w_pair != '0) && ((w_pair & (w_pair - LSB_ONE)) == '0)
                        && (plane_i == (w_pair | (w_pair << 1)));

    always_comb begin
        w_idx_single = '0;
        w_idx_pair   = '0;
        for (int i = 0; i < PLANE_W; i++) begin
            if (plane_i[i]) w_idx_single = w_idx_single | IDX_W'(i);
            if (w_pair[i])  w_idx_pair   = w_idx_pair | IDX_W'(i);
        end
    end

    always_comb begin
        code_o = '0;
        size_o = '0;
        if (!is_zero_o) begin
            if (w_all_ones) begin
                code_o[CW-1 -: BPC_PFX_W] = BPC_PFX_ONES;
                size_o                    = SZ_W'(BPC_PFX_W);
            end else if (dbp_flag_i) begin
                code_o[CW-1 -: BPC_PFX_W] = BPC_PFX_DBP;
                size_o                    = SZ_W'(BPC_PFX_W);
            end else if (w_cons) begin
                code_o[CW-1 -: POS_W] = {BPC_PFX_CONS, w_idx_pair};
                size_o                = SZ_W'(POS_W);
            end else if (w_single) begin
                code_o[CW-1 -: POS_W] = {BPC_PFX_SINGLE, w_idx_single};
                size_o                = SZ_W'(POS_W);
            end else begin
                code_o = {1'b1, plane_i};
                size_o = SZ_W'(CW);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bpc_dbx_stream_enc.sv
// ============================================================================
// Module   : bpc_dbx_stream_enc
// Brief    : Streaming DBX-plane encoder with zero-run merging and a single
//            registered output stage. Optional statistics counters are
//            built when BPC_DBX_STATS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bpc_dbx_stream_enc
    import bpc_pkg::*;
#(
    parameter int  PLANE_W = 63,
    parameter int  IDX_W   = $clog2(PLANE_W),
    parameter int  RUN_W   = 5,
    localparam int SZ_W    = bpc_sz_w(PLANE_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [PLANE_W-1:0] s_plane,
    input  logic               s_dbp_flag,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [PLANE_W:0]   m_codeword,
    output logic [SZ_W-1:0]    m_size,
    output logic               m_last,
    output logic [31:0]        stat_bits,
    output logic [31:0]        stat_planes
);

    localparam int RUN_MAX = 2**RUN_W + 1;
    localparam int CNT_W   = $clog2(RUN_MAX + 1);
    localparam int CW      = PLANE_W + 1;

    bpc_state_e       state_q;
    logic [CNT_W-1:0] run_cnt_q;
    logic [CNT_W-1:0] run_len_d;
    logic             m_valid_q;
    logic             m_last_q;
    logic [PLANE_W:0] m_codeword_q;
    logic [SZ_W-1:0]  m_size_q;
    logic             pend_last_q;
    logic [PLANE_W:0] pend_code_q;
    logic [SZ_W-1:0]  pend_size_q;

    logic             w_is_zero;
    logic [PLANE_W:0] w_cls_code;
    logic [SZ_W-1:0]  w_cls_size;
    logic [PLANE_W:0] w_run_code;
    logic [SZ_W-1:0]  w_run_size;
    logic             w_slot_free;
    logic             w_accept;
    logic             w_run_done;

    bpc_dbx_classify #(
        .PLANE_W (PLANE_W),
        .IDX_W   (IDX_W)
    ) u_classify (
        .plane_i    (s_plane),
        .dbp_flag_i (s_dbp_flag),
        .is_zero_o  (w_is_zero),
        .code_o     (w_cls_code),
        .size_o     (w_cls_size)
    );

    assign w_slot_free = !m_valid_q || m_ready;
    assign s_ready     = w_slot_free && (state_q != PEND);
    assign w_accept    = s_valid && s_ready;
    // Run length including the incoming plane when that plane is zero
    assign run_len_d   = w_is_zero ? run_cnt_q + CNT_W'(1) : run_cnt_q;
    assign w_run_done  = (run_len_d == CNT_W'(RUN_MAX)) || s_last;

    always_comb begin
        w_run_code = '0;
        w_run_size = '0;
        if (run_len_d == CNT_W'(1)) begin
            w_run_code[CW-1 -: 3] = BPC_PFX_RUN1;
            w_run_size            = SZ_W'(3);
        end else begin
            w_run_code[CW-1 -: 2+RUN_W] = {BPC_PFX_RUNN, RUN_W'(run_len_d - CNT_W'(2))};
            w_run_size                  = SZ_W'(2 + RUN_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PASS;
            run_cnt_q    <= '0;
            m_valid_q    <= 1'b0;
            m_codeword_q <= '0;
            m_size_q     <= '0;
            m_last_q     <= 1'b0;
            pend_code_q  <= '0;
            pend_size_q  <= '0;
            pend_last_q  <= 1'b0;
        end else begin
            if (m_valid_q && m_ready) m_valid_q <= 1'b0;
            if (w_accept) begin
                case (state_q)
                    PASS: begin
                        if (!w_is_zero) begin
                            m_valid_q    <= 1'b1;
                            m_codeword_q <= w_cls_code;
                            m_size_q     <= w_cls_size;
                            m_last_q     <= s_last;
                        end else if (w_run_done) begin
                            m_valid_q    <= 1'b1;
                            m_codeword_q <= w_run_code;
                            m_size_q     <= w_run_size;
                            m_last_q     <= s_last;
                        end else begin
                            run_cnt_q <= run_len_d;
                            state_q   <= RUN;
                        end
                    end
                    RUN: begin
                        if (!w_is_zero) begin
                            // Close the run now; the plane's own code waits one slot
                            m_valid_q    <= 1'b1;
                            m_codeword_q <= w_run_code;
                            m_size_q     <= w_run_size;
                            m_last_q     <= 1'b0;
                            pend_code_q  <= w_cls_code;
                            pend_size_q  <= w_cls_size;
                            pend_last_q  <= s_last;
                            run_cnt_q    <= '0;
                            state_q      <= PEND;
                        end else if (w_run_done) begin
                            m_valid_q    <= 1'b1;
                            m_codeword_q <= w_run_code;
                            m_size_q     <= w_run_size;
                            m_last_q     <= s_last;
                            run_cnt_q    <= '0;
                            state_q      <= PASS;
                        end else begin
                            run_cnt_q <= run_len_d;
                        end
                    end
                    default: ;
                endcase
            end else if (state_q == PEND && w_slot_free) begin
                m_valid_q    <= 1'b1;
                m_codeword_q <= pend_code_q;
                m_size_q     <= pend_size_q;
                m_last_q     <= pend_last_q;
                state_q      <= PASS;
            end
        end
    end

    assign m_valid    = m_valid_q;
    assign m_codeword = m_codeword_q;
    assign m_size     = m_size_q;
    assign m_last     = m_last_q;

`ifdef BPC_DBX_STATS_EN
    logic [31:0] stat_bits_q;
    logic [31:0] stat_planes_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bits_q   <= '0;
            stat_planes_q <= '0;
        end else begin
            if (m_valid_q && m_ready) stat_bits_q <= stat_bits_q + 32'(m_size_q);
            if (w_accept) stat_planes_q <= stat_planes_q + 32'd1;
        end
    end

    assign stat_bits   = stat_bits_q;
    assign stat_planes = stat_planes_q;
`else
    assign stat_bits   = '0;
    assign stat_planes = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bpc_dbx_stream_enc.sv
// ============================================================================
// Module   : tb_bpc_dbx_stream_enc
// Brief    : Self-checking bench for bpc_dbx_stream_enc: directed cases with
//            literal codewords plus randomized traffic against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bpc_dbx_stream_enc;

    localparam int PW      = 63;
    localparam int RUN_MAX = 33;

    logic          clk        = 1'b0;
    logic          rst        = 1'b1;
    logic          s_valid    = 1'b0;
    logic [PW-1:0] s_plane    = '0;
    logic          s_dbp_flag = 1'b0;
    logic          s_last     = 1'b0;
    logic          m_ready    = 1'b1;
    logic          s_ready;
    logic          m_valid;
    logic [PW:0]   m_codeword;
    logic [6:0]    m_size;
    logic          m_last;
    logic [31:0]   stat_bits;
    logic [31:0]   stat_planes;

    always #5 clk = ~clk;

    bpc_dbx_stream_enc dut (
        .clk         (clk),
        .rst         (rst),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_plane     (s_plane),
        .s_dbp_flag  (s_dbp_flag),
        .s_last      (s_last),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .m_codeword  (m_codeword),
        .m_size      (m_size),
        .m_last      (m_last),
        .stat_bits   (stat_bits),
        .stat_planes (stat_planes)
    );

    typedef struct {
        logic [63:0] cw;
        int          size;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    int          run_len    = 0;
    logic [31:0] exp_bits   = '0;
    logic [31:0] exp_planes = '0;
    int          n_checks   = 0;
    int          n_fail     = 0;

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    // Reference codes built from the code table as plain values, then left-aligned
    function automatic exp_t mk(input int size, input logic [63:0] val, input logic last);
        exp_t e;
        e.cw   = val << (64 - size);
        e.size = size;
        e.last = last;
        return e;
    endfunction

    function automatic exp_t run_code(input int len, input logic last);
        if (len == 1) return mk(3, 64'd1, last);
        return mk(7, 64'(32 + len - 2), last);
    endfunction

    function automatic exp_t plane_code(input logic [PW-1:0] p, input logic d, input logic last);
        int n;
        int lo;
        n  = $countones(p);
        lo = 0;
        for (int i = PW - 1; i >= 0; i--) if (p[i]) lo = i;
        if (n == PW) return mk(5, 64'd0, last);
        if (d) return mk(5, 64'd1, last);
        if (n == 2 && (p >> lo) == 63'd3) return mk(11, 64'(2 * 64 + lo), last);
        if (n == 1) return mk(11, 64'(3 * 64 + lo), last);
        return mk(64, {1'b1, p}, last);
    endfunction

    task automatic model_accept(input logic [PW-1:0] p, input logic d, input logic l);
        if (p == '0) begin
            run_len++;
            if (l || run_len == RUN_MAX) begin
                exp_q.push_back(run_code(run_len, l));
                run_len = 0;
            end
        end else begin
            if (run_len > 0) begin
                exp_q.push_back(run_code(run_len, 1'b0));
                run_len = 0;
            end
            exp_q.push_back(plane_code(p, d, l));
        end
    endtask

    // Compare process: every falling edge, outputs and handshakes are stable
    initial begin
        logic        after_rst;
        logic        stall;
        logic [63:0] held_cw;
        logic [6:0]  held_size;
        logic        held_last;
        exp_t        e;
        after_rst = 1'b0;
        stall     = 1'b0;
        held_cw   = '0;
        held_size = '0;
        held_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                run_len    = 0;
                exp_bits   = '0;
                exp_planes = '0;
                after_rst  = 1'b1;
                stall      = 1'b0;
            end else begin
                if (after_rst) begin
                    check("reset m_valid", 64'(m_valid), 64'd0);
                    check("reset m_codeword", m_codeword, 64'd0);
                    check("reset m_size", 64'(m_size), 64'd0);
                    check("reset m_last", 64'(m_last), 64'd0);
                    check("reset s_ready", 64'(s_ready), 64'd1);
                    after_rst = 1'b0;
                end
                if (stall) begin
                    check("hold m_valid", 64'(m_valid), 64'd1);
                    check("hold m_codeword", m_codeword, held_cw);
                    check("hold m_size", 64'(m_size), 64'(held_size));
                    check("hold m_last", 64'(m_last), 64'(held_last));
                end
                check("stat_bits", 64'(stat_bits), 64'(exp_bits));
                check("stat_planes", 64'(stat_planes), 64'(exp_planes));
                if (m_valid && !m_ready) check("s_ready while slot busy", 64'(s_ready), 64'd0);
                if (m_valid && m_ready) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected codeword: got %h size %0d, expected none",
                                 m_codeword, m_size);
                    end else begin
                        e = exp_q.pop_front();
                        check("model m_codeword", m_codeword, e.cw);
                        check("model m_size", 64'(m_size), 64'(e.size));
                        check("model m_last", 64'(m_last), 64'(e.last));
`ifdef BPC_DBX_STATS_EN
                        exp_bits = exp_bits + 32'(e.size);
`endif
                    end
                end
                if (s_valid && s_ready) begin
                    model_accept(s_plane, s_dbp_flag, s_last);
`ifdef BPC_DBX_STATS_EN
                    exp_planes = exp_planes + 32'd1;
`endif
                end
                stall     = m_valid && !m_ready;
                held_cw   = m_codeword;
                held_size = m_size;
                held_last = m_last;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [PW-1:0] p, input logic d, input logic l);
        int t;
        t          = 0;
        s_valid    = 1'b1;
        s_plane    = p;
        s_dbp_flag = d;
        s_last     = l;
        @(negedge clk);
        while (!s_ready && t < 100) begin
            t++;
            @(negedge clk);
        end
        if (!s_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL send timeout: got s_ready=0, expected 1 within 100 cycles");
        end
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [63:0] cw,
                           input int sz, input logic l);
        check({nm, " m_valid"}, 64'(m_valid), 64'(v));
        check({nm, " m_codeword"}, m_codeword, cw);
        check({nm, " m_size"}, 64'(m_size), 64'(sz));
        check({nm, " m_last"}, 64'(m_last), 64'(l));
    endtask

    function automatic logic [PW-1:0] rand_plane(input bit zero_heavy);
        int k;
        k = $urandom_range(0, 19);
        if (zero_heavy) return (k < 19) ? '0 : PW'({$urandom(), $urandom()});
        case (k)
            0, 1, 2, 3, 4, 5, 6, 7: return '0;
            8, 9:   return '1;
            10, 11, 12: return PW'(1) << $urandom_range(0, PW - 1);
            13, 14, 15: return PW'(3) << $urandom_range(0, PW - 2);
            default: return PW'({$urandom(), $urandom()});
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        bit   zh;
        repeat (3) cyc();
        rst = 1'b0;

        // Single one at bit 5, last set
        send(PW'(1) << 5, 1'b0, 1'b1);
        #2 chk_out("T1", 1'b1, 64'h18A0_0000_0000_0000, 11, 1'b1);

        // Run of three, then an adjacent pair at bit 0
        send('0, 1'b0, 1'b0);
        send('0, 1'b0, 1'b0);
        send('0, 1'b0, 1'b0);
        send(PW'(3), 1'b0, 1'b0);
        #2 chk_out("T2 run", 1'b1, 64'h4200_0000_0000_0000, 7, 1'b0);
        check("T2 s_ready pend", 64'(s_ready), 64'd0);
        cyc();
        #2 chk_out("T2 pair", 1'b1, 64'h1000_0000_0000_0000, 11, 1'b0);
        check("T2 s_ready after", 64'(s_ready), 64'd1);

        // 35 zeros: full run of 33 then run of 2 closing the block
        for (int i = 0; i < 35; i++) begin
            send('0, 1'b0, i == 34);
            if (i == 32) #2 chk_out("T3 max", 1'b1, 64'h7E00_0000_0000_0000, 7, 1'b0);
        end
        #2 chk_out("T3 tail", 1'b1, 64'h4000_0000_0000_0000, 7, 1'b1);

        send('1, 1'b1, 1'b0);
        #2 chk_out("T4 ones", 1'b1, 64'h0, 5, 1'b0);
        send(PW'(5), 1'b0, 1'b1);
        #2 chk_out("T4 raw", 1'b1, 64'h8000_0000_0000_0005, 64, 1'b1);

        // Backpressure with a pending code
        cyc();
        m_ready = 1'b0;
        send('0, 1'b0, 1'b0);
        send(PW'(7), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            #2 chk_out("T5 stall", 1'b1, 64'h2000_0000_0000_0000, 3, 1'b0);
            check("T5 s_ready", 64'(s_ready), 64'd0);
            cyc();
        end
        m_ready = 1'b1;
        cyc();
        #2 chk_out("T5 pend", 1'b1, 64'h8000_0000_0000_0007, 64, 1'b0);
        check("T5 s_ready after", 64'(s_ready), 64'd1);
        cyc();

        acc = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            zh = ((c / 500) % 2) == 1;
            if (!s_valid || acc) begin
                s_valid    = ($urandom_range(0, 9) < 7);
                s_plane    = rand_plane(zh);
                s_dbp_flag = ($urandom_range(0, 9) == 0);
                s_last     = zh ? ($urandom_range(0, 99) == 0) : ($urandom_range(0, 9) == 0);
            end
            m_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            acc = s_valid && s_ready;
            cyc();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (5) cyc();
        check("random drain queue empty", 64'(exp_q.size()), 64'd0);

        // Reset mid-run with seven zeros counted
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 7; i++) send('0, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #2 chk_out("T6 reset", 1'b0, 64'h0, 0, 1'b0);
        check("T6 s_ready", 64'(s_ready), 64'd1);
        send('0, 1'b0, 1'b1);
        #2 chk_out("T6 run1", 1'b1, 64'h2000_0000_0000_0000, 3, 1'b1);

        // Reset while a code is pending must drop it
        cyc();
        m_ready = 1'b0;
        send('0, 1'b0, 1'b0);
        send(PW'(9), 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst     = 1'b0;
        m_ready = 1'b1;
        repeat (4) cyc();
        #2 check("T6 no pending after reset", 64'(m_valid), 64'd0);
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
